// File: rtl/int_to_digits.sv
// Binary-to-BCD converter: one decimal digit per cycle via repeated division by ten.
// Includes the single combinational div10 stage used by the converter.

`ifndef INT_BITS
`define INT_BITS 32
`endif

module div10 #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] dividend_i,
    output logic [W-1:0] quotient_o,
    output logic [3:0]   remainder_o
);

    assign quotient_o  = dividend_i / W'(10);
    assign remainder_o = 4'(dividend_i % W'(10));

endmodule

module int_to_digits #(
    parameter int unsigned DIGITS = 10
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [`INT_BITS-1:0]           in_value,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [4*DIGITS-1:0]            digits,
    output logic [DIGITS-1:0]              digit_en,
    output logic [$clog2(DIGITS+1)-1:0]    ndigits,
    output logic                           overflow
);

    localparam int unsigned IntBits = `INT_BITS;
    localparam int unsigned CntW    = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

    state_e               state_q, state_d;
    logic [IntBits-1:0]   work_q, work_d;
    logic [CntW-1:0]      index_q, index_d;
    logic [4*DIGITS-1:0]  digits_q, digits_d;
    logic [DIGITS-1:0]    digit_en_q, digit_en_d;
    logic [CntW-1:0]      ndigits_q, ndigits_d;
    logic                 overflow_q, overflow_d;

    logic [IntBits-1:0]   quot;
    logic [3:0]           rem;

    div10 #(
        .W (IntBits)
    ) u_div10 (
        .dividend_i  (work_q),
        .quotient_o  (quot),
        .remainder_o (rem)
    );

    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        index_d    = index_q;
        digits_d   = digits_q;
        digit_en_d = digit_en_q;
        ndigits_d  = ndigits_q;
        overflow_d = overflow_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    work_d     = in_value;
                    index_d    = '0;
                    digits_d   = '0;
                    digit_en_d = '0;
                    ndigits_d  = '0;
                    overflow_d = 1'b0;
                    state_d    = StConv;
                end
            end
            StConv: begin
                for (int k = 0; k < int'(DIGITS); k++) begin
                    if (index_q == CntW'(k)) begin
                        digits_d[4*k +: 4] = rem;
                        digit_en_d[k]      = 1'b1;
                    end
                end
                work_d    = quot;
                index_d   = index_q + CntW'(1);
                ndigits_d = index_q + CntW'(1);
                // A non-zero quotient can only survive to here on the last slot.
                if (quot == '0 || index_q == CntW'(DIGITS - 1)) begin
                    overflow_d = (quot != '0);
                    state_d    = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            work_q     <= '0;
            index_q    <= '0;
            digits_q   <= '0;
            digit_en_q <= '0;
            ndigits_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            index_q    <= index_d;
            digits_q   <= digits_d;
            digit_en_q <= digit_en_d;
            ndigits_q  <= ndigits_d;
            overflow_q <= overflow_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign digits    = digits_q;
    assign digit_en  = digit_en_q;
    assign ndigits   = ndigits_q;
    assign overflow  = overflow_q;

endmodule
